// File: rtl/serv_mem_pkg.sv
// serv_mem_pkg: shared definitions for the serv_mem_align data-bus block.
//   - access size encodings (SIZE_B / SIZE_H / SIZE_W; 2'b11 behaves as word)
//   - FSM state type
//   - lane_mask():  8-bit byte-lane mask of an access, spanning two words
//   - misaligned(): accesses that trap when MEM_MISALIGN_SPLIT_EN is undefined
package serv_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StAcc0,
        StAcc1,
        StFin
    } state_e;

    // Bits [3:0] are lanes of the first word, bits [7:4] lanes of the next word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] adr);
        logic [7:0] base;
        case (size)
            SIZE_B:  base = 8'h01;
            SIZE_H:  base = 8'h03;
            default: base = 8'h0f;
        endcase
        return base << adr;
    endfunction

    // size[1] covers both 2'b10 and the word-alias 2'b11.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] adr);
        return ((size == SIZE_H) && adr[0]) || (size[1] && (adr != 2'b00));
    endfunction

endpackage

// File: rtl/serv_mem_lane.sv
// serv_mem_lane: combinational lane steering for serv_mem_align.
// Ports:
//   i_adr[1:0], i_size  - byte offset and size of the latched access
//   i_signed            - sign-extend the load result
//   i_wdat              - LSB-aligned store data
//   i_ldat              - merged load word as it sits on the bus lanes
//   o_mask              - 8-bit lane mask (two words)
//   o_split             - access touches the following word
//   o_wdat              - store data rotated left onto its lanes
//   o_ldat              - load data rotated right, masked to size, extended
// Split handling is enabled in the parent by MEM_MISALIGN_SPLIT_EN.
module serv_mem_lane
    import serv_mem_pkg::*;
(
    input  logic [1:0]  i_adr,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdat,
    input  logic [31:0] i_ldat,
    output logic [7:0]  o_mask,
    output logic        o_split,
    output logic [31:0] o_wdat,
    output logic [31:0] o_ldat
);

    logic [31:0] rot;

    always_comb begin
        o_mask  = lane_mask(i_size, i_adr);
        o_split = |o_mask[7:4];

        case (i_adr)
            2'd0:    o_wdat = i_wdat;
            2'd1:    o_wdat = {i_wdat[23:0], i_wdat[31:24]};
            2'd2:    o_wdat = {i_wdat[15:0], i_wdat[31:16]};
            default: o_wdat = {i_wdat[7:0],  i_wdat[31:8]};
        endcase

        case (i_adr)
            2'd0:    rot = i_ldat;
            2'd1:    rot = {i_ldat[7:0],  i_ldat[31:8]};
            2'd2:    rot = {i_ldat[15:0], i_ldat[31:16]};
            default: rot = {i_ldat[23:0], i_ldat[31:24]};
        endcase

        case (i_size)
            SIZE_B:  o_ldat = {{24{i_signed & rot[7]}},  rot[7:0]};
            SIZE_H:  o_ldat = {{16{i_signed & rot[15]}}, rot[15:0]};
            default: o_ldat = rot;
        endcase
    end

endmodule

// File: rtl/serv_mem_align.sv
// serv_mem_align: owns the data-bus transaction for core loads and stores.
// A request is latched in IDLE, issued as one Wishbone cycle (or two when the
// access crosses a word boundary), merged, aligned, extended and stored in a
// result register that the core shifts out W bits at a time.
// Ports:
//   i_clk, i_rst_n                     - clock, asynchronous active-low reset
//   i_req/i_we/i_size/i_signed/i_adr/i_wdat - access request from the core
//   o_busy, o_done, o_misalign         - status back to the core
//   i_rd_en, o_rd                      - serial readout of the load result
//   o_wb_* / i_wb_rdt / i_wb_ack       - data Wishbone master port
// Macro MEM_MISALIGN_SPLIT_EN: defined -> word-crossing accesses are split;
// undefined -> misaligned halves/words trap without a bus cycle.
module serv_mem_align
    import serv_mem_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_req,
    input  logic          i_we,
    input  logic [1:0]    i_size,
    input  logic          i_signed,
    input  logic [31:0]   i_adr,
    input  logic [31:0]   i_wdat,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_misalign,
    input  logic          i_rd_en,
    output logic [W-1:0]  o_rd,
    output logic [31:0]   o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack
);

`ifdef MEM_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    state_e      state_q;
    logic [1:0]  adr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        we_q;
    logic [31:0] wdat_q;
    logic [31:0] wb_adr_q;
    logic [3:0]  sel_q;
    logic        cyc_q;
    logic        done_q;
    logic        misalign_q;
    logic [31:0] cap_q;
    logic [31:0] res_q;

    logic [7:0]  mask;
    logic        split;
    logic [31:0] wdat_rot;
    logic [31:0] ldat_ext;
    logic [31:0] merged;
    logic [3:0]  hit;
    logic        acc_ack;
    logic        last_ack;

    serv_mem_lane u_lane (
        .i_adr    (adr_q),
        .i_size   (size_q),
        .i_signed (signed_q),
        .i_wdat   (wdat_q),
        .i_ldat   (merged),
        .o_mask   (mask),
        .o_split  (split),
        .o_wdat   (wdat_rot),
        .o_ldat   (ldat_ext)
    );

    // Lanes delivered by the current ack overwrite the capture word; the rest
    // keep what an earlier access phase captured.
    always_comb begin
        hit = 4'b0000;
        if (state_q == StAcc0) begin
            hit = mask[3:0];
        end else if (state_q == StAcc1) begin
            hit = mask[7:4];
        end
        merged = cap_q;
        for (int b = 0; b < 4; b++) begin
            if (hit[b]) begin
                merged[8*b +: 8] = i_wb_rdt[8*b +: 8];
            end
        end
        acc_ack  = i_wb_ack && ((state_q == StAcc0) || (state_q == StAcc1));
        last_ack = i_wb_ack && (((state_q == StAcc0) && !(SplitEn && split)) ||
                                (state_q == StAcc1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            adr_q      <= 2'b00;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            we_q       <= 1'b0;
            wdat_q     <= 32'h0;
            wb_adr_q   <= 32'h0;
            sel_q      <= 4'h0;
            cyc_q      <= 1'b0;
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_req) begin
                        if (!SplitEn && misaligned(i_size, i_adr[1:0])) begin
                            done_q     <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q  <= StAcc0;
                            adr_q    <= i_adr[1:0];
                            size_q   <= i_size;
                            signed_q <= i_signed;
                            we_q     <= i_we;
                            wdat_q   <= i_wdat;
                            wb_adr_q <= {i_adr[31:2], 2'b00};
                            sel_q    <= 4'(lane_mask(i_size, i_adr[1:0]));
                            cyc_q    <= 1'b1;
                        end
                    end
                end
                StAcc0: begin
                    if (i_wb_ack) begin
                        if (SplitEn && split) begin
                            state_q  <= StAcc1;
                            wb_adr_q <= wb_adr_q + 32'd4;
                            sel_q    <= mask[7:4];
                        end else begin
                            state_q <= StFin;
                            cyc_q   <= 1'b0;
                            sel_q   <= 4'h0;
                            we_q    <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StAcc1: begin
`ifdef MEM_MISALIGN_SPLIT_EN
                    if (i_wb_ack) begin
                        state_q <= StFin;
                        cyc_q   <= 1'b0;
                        sel_q   <= 4'h0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end
`else
                    state_q <= StIdle;
                    cyc_q   <= 1'b0;
                    sel_q   <= 4'h0;
                    we_q    <= 1'b0;
`endif
                end
                StFin:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // we_q is still the latched value in the cycle of the final ack.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_q <= 32'h0;
            res_q <= 32'h0;
        end else begin
            if (acc_ack && !we_q) begin
                cap_q <= merged;
            end
            if (last_ack && !we_q) begin
                res_q <= ldat_ext;
            end else if (i_rd_en) begin
                res_q <= res_q >> W;
            end
        end
    end

    assign o_busy     = (state_q != StIdle);
    assign o_done     = done_q;
    assign o_misalign = misalign_q;
    assign o_rd       = res_q[W-1:0];
    assign o_wb_adr   = wb_adr_q;
    assign o_wb_dat   = wdat_rot;
    assign o_wb_sel   = sel_q;
    assign o_wb_we    = we_q;
    assign o_wb_cyc   = cyc_q;

endmodule

// File: tb/tb_serv_mem_align.sv
// Testbench for serv_mem_align (W=1): a table of single-phase accesses plus
// hand-written split, trap and reset sequences. Expectations follow the build
// selected by MEM_MISALIGN_SPLIT_EN.
module tb_serv_mem_align;

    localparam int W = 1;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_req = 1'b0;
    logic          i_we = 1'b0;
    logic [1:0]    i_size = 2'b00;
    logic          i_signed = 1'b0;
    logic [31:0]   i_adr = 32'h0;
    logic [31:0]   i_wdat = 32'h0;
    logic          i_rd_en = 1'b0;
    logic [31:0]   i_wb_rdt = 32'h0;
    logic          i_wb_ack = 1'b0;
    logic          o_busy, o_done, o_misalign, o_wb_we, o_wb_cyc;
    logic [W-1:0]  o_rd;
    logic [31:0]   o_wb_adr, o_wb_dat;
    logic [3:0]    o_wb_sel;

    serv_mem_align #(.W(W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_size     (i_size),
        .i_signed   (i_signed),
        .i_adr      (i_adr),
        .i_wdat     (i_wdat),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_misalign (o_misalign),
        .i_rd_en    (i_rd_en),
        .o_rd       (o_rd),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .i_wb_rdt   (i_wb_rdt),
        .i_wb_ack   (i_wb_ack)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdt;
        logic        trap;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        rdout;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic readout(output logic [31:0] v);
        v = 32'h0;
        for (int i = 0; i < 32 / W; i++) begin
            v[i*W +: W] = o_rd;
            i_rd_en = 1'b1;
            @(negedge i_clk);
        end
        i_rd_en = 1'b0;
    endtask

    task automatic start(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] adr, input logic [31:0] wdat);
        i_req = 1'b1;
        i_we = we;
        i_size = size;
        i_signed = sgn;
        i_adr = adr;
        i_wdat = wdat;
        @(negedge i_clk);
        i_req = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rdt);
        i_wb_ack = 1'b1;
        i_wb_rdt = rdt;
        @(negedge i_clk);
        i_wb_ack = 1'b0;
        i_wb_rdt = 32'h0;
    endtask

    task automatic run(input vec_t v, input int idx);
        logic [31:0] r;
        start(v.we, v.size, v.sgn, v.adr, v.wdat);
        if (v.trap) begin
            chk($sformatf("v%0d trap done", idx), 32'(o_done), 32'd1);
            chk($sformatf("v%0d trap misalign", idx), 32'(o_misalign), 32'd1);
            chk($sformatf("v%0d trap cyc", idx), 32'(o_wb_cyc), 32'd0);
            chk($sformatf("v%0d trap busy", idx), 32'(o_busy), 32'd0);
            @(negedge i_clk);
            chk($sformatf("v%0d trap done drop", idx), 32'(o_done), 32'd0);
        end else begin
            chk($sformatf("v%0d cyc", idx), 32'(o_wb_cyc), 32'd1);
            chk($sformatf("v%0d busy", idx), 32'(o_busy), 32'd1);
            chk($sformatf("v%0d sel", idx), 32'(o_wb_sel), 32'(v.sel));
            chk($sformatf("v%0d adr", idx), o_wb_adr, {v.adr[31:2], 2'b00});
            chk($sformatf("v%0d we", idx), 32'(o_wb_we), 32'(v.we));
            if (v.we) chk($sformatf("v%0d dat", idx), o_wb_dat, v.dat);
            @(negedge i_clk);
            chk($sformatf("v%0d wait cyc", idx), 32'(o_wb_cyc), 32'd1);
            chk($sformatf("v%0d wait done", idx), 32'(o_done), 32'd0);
            ack(v.rdt);
            chk($sformatf("v%0d done", idx), 32'(o_done), 32'd1);
            chk($sformatf("v%0d misalign", idx), 32'(o_misalign), 32'd0);
            chk($sformatf("v%0d cyc end", idx), 32'(o_wb_cyc), 32'd0);
            @(negedge i_clk);
            chk($sformatf("v%0d done drop", idx), 32'(o_done), 32'd0);
            chk($sformatf("v%0d idle", idx), 32'(o_busy), 32'd0);
        end
        if (v.rdout) begin
            readout(r);
            chk($sformatf("v%0d result", idx), r, v.res);
        end
    endtask

    initial begin
        logic [31:0] r;
        //          we    size   sgn   adr           wdat          rdt
        //          trap  sel    dat           rdout res
        vecs[0] = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF,
                    1'b0, 4'hF, 32'h0, 1'b1, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h8000_0000,
                    1'b0, 4'h8, 32'h0, 1'b1, 32'hFFFF_FF80};
        vecs[2] = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h8000_0000,
                    1'b0, 4'h8, 32'h0, 1'b1, 32'h0000_0080};
        vecs[3] = '{1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_0000,
                    1'b0, 4'hC, 32'h0, 1'b1, 32'hFFFF_8001};
        vecs[4] = '{1'b0, 2'b01, 1'b0, 32'h0000_0200, 32'h0, 32'h1234_ABCD,
                    1'b0, 4'h3, 32'h0, 1'b0, 32'h0};
        // Store leaves the unread result of vecs[4] in place.
        vecs[5] = '{1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_00A5, 32'hFFFF_FFFF,
                    1'b0, 4'h2, 32'h0000_A500, 1'b1, 32'h0000_ABCD};
`ifdef MEM_MISALIGN_SPLIT_EN
        vecs[6] = '{1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 32'h00BE_EF00,
                    1'b0, 4'h6, 32'h0, 1'b1, 32'h0000_BEEF};
`else
        vecs[6] = '{1'b0, 2'b01, 1'b0, 32'h0000_0101, 32'h0, 32'h00BE_EF00,
                    1'b1, 4'h0, 32'h0, 1'b1, 32'h0};
`endif
        vecs[7] = '{1'b0, 2'b11, 1'b0, 32'h0000_0300, 32'h0, 32'h0102_0304,
                    1'b0, 4'hF, 32'h0, 1'b1, 32'h0102_0304};

        repeat (2) @(negedge i_clk);
        chk("reset cyc", 32'(o_wb_cyc), 32'd0);
        chk("reset busy", 32'(o_busy), 32'd0);
        chk("reset done", 32'(o_done), 32'd0);
        chk("reset sel", 32'(o_wb_sel), 32'd0);
        chk("reset adr", o_wb_adr, 32'd0);
        chk("reset rd", 32'(o_rd), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 8; i++) run(vecs[i], i);

        // Ack while idle must be ignored.
        ack(32'hFFFF_FFFF);
        chk("idle ack done", 32'(o_done), 32'd0);
        chk("idle ack busy", 32'(o_busy), 32'd0);

`ifdef MEM_MISALIGN_SPLIT_EN
        start(1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1122_3344);
        chk("sw c1 adr", o_wb_adr, 32'h0000_0100);
        chk("sw c1 sel", 32'(o_wb_sel), 32'hC);
        chk("sw c1 dat", o_wb_dat, 32'h3344_1122);
        ack(32'h0);
        chk("sw c2 cyc", 32'(o_wb_cyc), 32'd1);
        chk("sw c2 adr", o_wb_adr, 32'h0000_0104);
        chk("sw c2 sel", 32'(o_wb_sel), 32'h3);
        chk("sw c2 dat", o_wb_dat, 32'h3344_1122);
        chk("sw c2 done", 32'(o_done), 32'd0);
        ack(32'h0);
        chk("sw done", 32'(o_done), 32'd1);
        @(negedge i_clk);

        start(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0);
        chk("lh c1 adr", o_wb_adr, 32'hFFFF_FFFC);
        chk("lh c1 sel", 32'(o_wb_sel), 32'h8);
        ack(32'hAB00_0000);
        chk("lh c2 adr", o_wb_adr, 32'h0000_0000);
        chk("lh c2 sel", 32'(o_wb_sel), 32'h1);
        ack(32'h0000_00CD);
        chk("lh done", 32'(o_done), 32'd1);
        @(negedge i_clk);
        readout(r);
        chk("lh result", r, 32'h0000_CDAB);

        // Reset while the second access is on the bus.
        start(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
        chk("rst c1 sel", 32'(o_wb_sel), 32'hE);
        ack(32'h0);
        chk("rst c2 sel", 32'(o_wb_sel), 32'h1);
`else
        start(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
        chk("lw101 done", 32'(o_done), 32'd1);
        chk("lw101 misalign", 32'(o_misalign), 32'd1);
        chk("lw101 cyc", 32'(o_wb_cyc), 32'd0);
        chk("lw101 busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        chk("lw101 busy after", 32'(o_busy), 32'd0);
        chk("lw101 misalign drop", 32'(o_misalign), 32'd0);

        // Reset while the access is on the bus.
        start(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
`endif
        chk("rst pre cyc", 32'(o_wb_cyc), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("rst cyc drop", 32'(o_wb_cyc), 32'd0);
        chk("rst busy drop", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        chk("rst no done", 32'(o_done), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        run(vecs[0], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
